// File: rtl/verdict_collector.sv
// verdict_collector
//   Samples the monitor output streams every cycle. Each cycle with at least
//   one active stream becomes a snapshot {timestamp, active mask, all values}
//   in a small FIFO. The snapshots leave as one record per active stream, in
//   ascending stream order, over a valid/ready stream.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   en         : global enable; gates timestamp advance and capture
//   out_data   : monitor values, stream k at [k*DATA_W +: DATA_W]
//   out_aktv   : per-stream active strobes
//   rec_valid  : record available (registered state, independent of rec_ready)
//   rec_ready  : consumer accepts the current record
//   rec_ts     : snapshot timestamp
//   rec_idx    : stream index of the current record
//   rec_data   : stream value of the current record (signed, unmodified)
//   rec_last   : current record is the last one of its snapshot
//   overflow   : sticky, set when a snapshot was dropped
//   drop_count : dropped snapshots, saturating at 0xFFFF
module verdict_collector #(
  parameter int NUM_OUT = 7,
  parameter int DATA_W  = 64,
  parameter int TS_W    = 32,
  parameter int DEPTH   = 16,
  parameter int IDX_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_OUT-1:0]        out_aktv,
  output logic                      rec_valid,
  input  logic                      rec_ready,
  output logic [TS_W-1:0]           rec_ts,
  output logic [IDX_W-1:0]          rec_idx,
  output logic signed [DATA_W-1:0]  rec_data,
  output logic                      rec_last,
  output logic                      overflow,
  output logic [15:0]               drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                    state, state_nxt;
  logic [TS_W-1:0]           ts;
  logic [TS_W-1:0]           mem_ts   [DEPTH];
  logic [NUM_OUT-1:0]        mem_mask [DEPTH];
  logic [NUM_OUT*DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CNT_W-1:0]          count;
  logic [NUM_OUT-1:0]        pending, pending_nxt, cur_bit, rest;
  logic                      capture, accept, drop, emit, xfer, is_last, pop;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [IDX_W-1:0] low_idx(input logic [NUM_OUT-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = NUM_OUT - 1; k >= 0; k--) begin
      if (m[k]) r = IDX_W'(k);
    end
    return r;
  endfunction

  always_comb begin
    emit       = (state == EMIT);
    capture    = en && (out_aktv != '0);
    xfer       = emit && rec_ready;
    // isolate the lowest pending stream; it is the record on the port
    cur_bit    = pending & (~pending + NUM_OUT'(1));
    rest       = pending & ~cur_bit;
    is_last    = (rest == '0);
    pop        = xfer && is_last;
    // a full FIFO still takes a snapshot when the head leaves on this edge
    accept     = capture && ((count != FULL) || pop);
    drop       = capture && !accept;
    rd_ptr_inc = rd_ptr + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      pending    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (en)     ts     <= ts + TS_W'(1);
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr_inc;
      case ({accept, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc16(drop_count);
      end
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // snapshot storage carries no reset; only occupied slots are ever read
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_ts[wr_ptr]   <= ts;
      mem_mask[wr_ptr] <= out_aktv;
      mem_data[wr_ptr] <= out_data;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt   = EMIT;
          pending_nxt = mem_mask[rd_ptr];
        end
      end
      EMIT: begin
        if (xfer) begin
          if (!is_last) begin
            pending_nxt = rest;
          end else if (count > ONE) begin
            // next snapshot was stored before this edge: no bubble
            pending_nxt = mem_mask[rd_ptr_inc];
          end else begin
            state_nxt   = IDLE;
            pending_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
      end
    endcase
  end

  always_comb begin
    rec_valid = emit;
    rec_ts    = '0;
    rec_idx   = '0;
    rec_data  = '0;
    rec_last  = 1'b0;
    if (emit) begin
      rec_ts   = mem_ts[rd_ptr];
      rec_idx  = low_idx(pending);
      rec_last = is_last;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (cur_bit[k]) rec_data = $signed(mem_data[rd_ptr][k*DATA_W +: DATA_W]);
      end
    end
  end

endmodule

// File: doc/verdict_collector.md
# verdict_collector

Sink-side counterpart to the monitor's per-stream input interface. It samples the monitor's output streams (`output_k` value plus `output_k_aktv` strobe) every cycle and timestamps each cycle with at least one active output. It buffers these snapshots in a FIFO and serializes them as one record per active output over a valid/ready stream toward a host/trace port. It sits directly after `topEntity` in on-chip runs, replacing the simulation-only `$display` printing.

## Interface
Parameters:
- `NUM_OUT`, 7, number of monitor output streams
- `DATA_W`, 64, width of each output value (signed, passed through unmodified)
- `TS_W`, 32, timestamp counter width
- `DEPTH`, 16, snapshot FIFO entries (power of two, ≥2)
- `IDX_W`, 3, width of the stream index, ≥ clog2(NUM_OUT)

Ports:
- `clk` in 1: the single clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: global enable, same meaning as the monitor's `en`.
- `out_data` in NUM_OUT*DATA_W: monitor values; stream k at bits [k*DATA_W +: DATA_W].
- `out_aktv` in NUM_OUT: per-stream active strobes.
- `rec_valid` out 1: record available.
- `rec_ready` in 1: consumer accepts a record.
- `rec_ts` out TS_W: cycle timestamp of the snapshot.
- `rec_idx` out IDX_W: stream index k.
- `rec_data` out DATA_W: value of stream k.
- `rec_last` out 1: last record of this snapshot.
- `overflow` out 1: sticky; a snapshot was dropped.
- `drop_count` out 16: number of dropped snapshots, saturating at 0xFFFF.

## Operation
- Timestamp counter `ts`:
  - Increments by 1 on every edge with `en`=1; holds when `en`=0.
  - Wraps modulo 2^TS_W.
  - The value before the increment is the one captured.
- Capture:
  - Occurs on an edge with `en`=1 and `out_aktv`≠0.
  - The entry written is {ts, out_aktv mask, full out_data}.
  - With `en`=0 nothing is captured.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count.
  - A capture is accepted if count<DEPTH, or if the same edge pops the head entry.
  - Otherwise the snapshot is dropped: `overflow` is set and `drop_count` increments, saturating.
- Serializer FSM, IDLE/EMIT:
  - IDLE: when the FIFO is non-empty, load `pending` ← head mask and go to EMIT.
  - EMIT outputs:
    - `rec_valid`=1.
    - `rec_idx` = lowest set bit of `pending`.
    - `rec_data` = head data slice at that index.
    - `rec_ts` = head ts.
    - `rec_last` = (`pending` has exactly one bit set).
  - On an edge with `rec_valid` & `rec_ready`:
    - Clear that bit.
    - If it was the last bit, pop the head.
    - Then, if another entry exists after the pop (excluding an entry written on the same edge), load its mask and stay in EMIT; otherwise go to IDLE.
- Draining continues while `en`=0.
- Records leave in timestamp order, and within a snapshot in ascending index order.

## Timing
- Reset values:
  - `rec_valid`=0, `rec_ts`=0, `rec_idx`=0, `rec_data`=0, `rec_last`=0.
  - `overflow`=0, `drop_count`=0.
  - ts=0, FIFO empty, FSM IDLE.
  - rec_* outputs are 0 whenever `rec_valid`=0.
- Latency: capture at edge N into an empty FIFO → `rec_valid` high after edge N+1.
- Throughput: one record per cycle with `rec_ready` held high, with no bubble between snapshots.
- Handshake:
  - While `rec_valid`=1 and `rec_ready`=0, all rec_* outputs are held stable.
  - `rec_valid` is never deasserted without a transfer.
  - `rec_valid` does not depend combinationally on `rec_ready`.
- When full, a simultaneous capture and final-record pop are both accepted; count stays DEPTH.
- Reset mid-record: outputs drop to 0 asynchronously and buffered data is discarded.
- The first ts after reset release is 0 on the first enabled edge.

## Test plan
- Single snapshot: reset, en=1, at ts=1000 drive aktv=0000001 with output_0=5, `rec_ready`=1 → one record (ts=1000, idx=0, data=5, last=1), with `rec_valid` high exactly one cycle.
- Multi-stream: aktv=1000101 at ts=20, values 1,2,3 on streams 0,2,6 → three consecutive records with idx 0,2,6, data 1,2,3, all ts=20, `rec_last` only on idx 6.
- Backpressure: two back-to-back snapshots (ts 7 and 8, one active each), `rec_ready`=0 for 5 cycles → first record stable for 5 cycles, then records ts=7 and ts=8 on consecutive cycles.
- Overflow: DEPTH=4, `rec_ready`=0, 6 consecutive active cycles → FIFO holds ts 0..3, `overflow`=1, `drop_count`=2; after ready is raised the records for ts 0..3 arrive in order.
- Enable and wrap: TS_W=4, en toggled low for 3 cycles while aktv pulses → no captures while en=0; captured ts sequence 14,15,0,1 across the wrap.
- Reset mid-drain: assert `rst`=0 while in EMIT with 3 entries queued → all outputs 0 immediately; after release, a new snapshot yields ts=0 as its first record.
